// File: rtl/mem_bus_arbiter_if.sv
// Two-requester memory bus bundle: requester ports, response path and the memory side.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface mem_bus_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_ack, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_ack, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between a CPU data port and a DMA/debug port onto one memory,
// one outstanding transaction at a time, with an optional per-transaction timeout.
module mem_bus_arbiter #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_id;
    logic              r_last_served;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [7:0]        r_cnt;

    logic              w_sel;
    logic              w_grant;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_next = S_WAIT;
            S_WAIT:  if (bus.mem_ack || w_timeout) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Contention goes to the port that was not served last; a lone request wins outright.
    always_comb begin
        w_sel     = (bus.req0 && bus.req1) ? ~r_last_served : bus.req1;
        w_grant   = (r_state == S_IDLE) && !rst && (bus.req0 || bus.req1);
        w_gnt0    = w_grant && !w_sel;
        w_gnt1    = w_grant && w_sel;
        w_timeout = (r_state == S_WAIT) && !bus.mem_ack && (TIMEOUT != 0)
                    && (({1'b0, r_cnt} + 9'd1) == TO_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id          <= 1'b0;
            r_last_served <= 1'b1;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_cnt         <= 8'd0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_id        <= w_sel;
                        r_mem_we    <= w_sel ? bus.we1    : bus.we0;
                        r_mem_addr  <= w_sel ? bus.addr1  : bus.addr0;
                        r_mem_wdata <= w_sel ? bus.wdata1 : bus.wdata0;
                        r_cnt       <= 8'd0;
                        r_mem_req   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // An ack landing on the timeout cycle still completes normally.
                    if (bus.mem_ack) begin
                        r_rdata   <= r_mem_we ? '0 : bus.mem_rdata;
                        r_err     <= 1'b0;
                        r_mem_req <= 1'b0;
                        r_rvalid0 <= ~r_id;
                        r_rvalid1 <= r_id;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_timeout) begin
                            r_rdata   <= '0;
                            r_err     <= 1'b1;
                            r_mem_req <= 1'b0;
                            r_rvalid0 <= ~r_id;
                            r_rvalid1 <= r_id;
                        end
                    end
                end
                S_RESP: r_last_served <= r_id;
                default: ;
            endcase
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, width of address and data fields on every port.
REQ-002 Parameter TIMEOUT, default 255, range 0..255: the number of mem_req cycles without mem_ack before a transaction is aborted. 0 disables the timeout.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0/req1  input  1 each  request from port 0 (CPU data port) / port 1 (DMA/debug port).
REQ-006 we0/we1  input  1 each  1 = write, 0 = read.
REQ-007 addr0/addr1  input  DATA_W each  byte address.
REQ-008 wdata0/wdata1  input  DATA_W each  write data.
REQ-009 gnt0/gnt1  output  1 each  request accepted this cycle (combinational).
REQ-010 rvalid0/rvalid1  output  1 each  response valid, one-cycle pulse, registered.
REQ-011 rdata  output  DATA_W  read data, shared by both ports, qualified by rvalid0/rvalid1.
REQ-012 err  output  1  transaction timed out, qualified by rvalid0/rvalid1.
REQ-013 mem_req  output  1  memory access active, registered.
REQ-014 mem_we, mem_addr, mem_wdata  output  1/DATA_W/DATA_W  latched transaction fields.
REQ-015 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-018 In IDLE, the arbiter SHALL select one requester:
- only one req high: that port is selected;
- both high: the port not recorded in last_served is selected.
REQ-019 gnt0/gnt1 SHALL be high only in IDLE, only for the selected port, and at most one at a time.
REQ-020 On the edge where gnt is high, the arbiter SHALL:
- latch we/addr/wdata of the selected port and its id;
- clear the timeout counter;
- enter WAIT.
REQ-021 In WAIT, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL hold the latched values unchanged.
REQ-022 In WAIT, when mem_ack=1 is sampled, the arbiter SHALL:
- capture mem_rdata into rdata (0 for writes);
- clear err;
- enter RESP.
REQ-023 In WAIT without mem_ack, the 8-bit timeout counter SHALL increment. When TIMEOUT!=0 and the counter reaches TIMEOUT, the arbiter SHALL set err=1 and rdata=0 and enter RESP.
REQ-024 mem_ack and a timeout occurring in the same cycle SHALL be resolved as a normal completion (ack wins).
REQ-025 In RESP, the arbiter SHALL:
- pulse rvalid of the latched id for exactly one cycle;
- set last_served to the latched id;
- set mem_req=0;
- return to IDLE.
REQ-026 Requests SHALL not be accepted in WAIT or RESP. Requesters SHALL hold req high until gnt; req changes while busy SHALL have no effect.
REQ-027 mem_ack sampled in IDLE or RESP SHALL be ignored.
REQ-028 Latency SHALL be as follows:
- gnt edge at cycle 0;
- mem_req high from cycle 1;
- mem_ack at cycle n (n>=1) gives rvalid in cycle n+1.
Minimum latency is 2 cycles from grant to response; throughput is at most one transaction per 3 cycles.
REQ-029 rdata and err SHALL hold their values after the rvalid pulse until the next RESP.

Reset
REQ-030 While rst=1, asynchronously:
- state=IDLE;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- rvalid0=rvalid1=0, rdata=0, err=0;
- timeout counter=0;
- last_served=1, so port 0 wins the first contention.
REQ-031 While rst=1, gnt0/gnt1 SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL drop mem_req immediately and discard the transaction, with no rvalid.
REQ-033 After reset deassertion, the first grant SHALL be possible on the first rising edge.

Verification
REQ-034 Single read: req0=1, we0=0, addr0=0x100; mem_ack=1 one cycle after mem_req rises with mem_rdata=0xDEAD -> gnt0 at cycle 0, mem_addr=0x100 from cycle 1, rvalid0=1 with rdata=0xDEAD, err=0 at cycle 3.
REQ-035 Contention: req0=req1=1 continuously after reset, instant acks -> grant order 0,1,0,1; rvalid never goes to the non-granted port.
REQ-036 Write: req1=1, we1=1, addr1=0x8, wdata1=0x55, ack after 4 wait cycles -> mem_we=1 and mem_wdata=0x55 held stable throughout; rvalid1 pulses with rdata=0.
REQ-037 Timeout: TIMEOUT=3, mem_ack never asserted -> rvalid0=1 with err=1, rdata=0 after 3 mem_req cycles; next request is accepted normally.
REQ-038 Reset mid-op: rst pulsed during WAIT -> mem_req=0 in the same cycle, no rvalid; afterwards simultaneous req0/req1 grants port 0.
REQ-039 Stray ack: mem_ack=1 held in IDLE with no req -> no rvalid, no state change.
